pcie_bw_sequencer: RTL and testbench
====================================

# pcie_bw_sequencer

Drives the `start_write` / `start_read` inputs of the AXI4 PCIe traffic generator directly upstream of it. It runs a programmed number of write-only, read-only or write-then-read iterations back to back. After each pass it captures `write_time` / `read_time` and keeps per-direction min/max/sum/count statistics, so software can compute bandwidth without polling every pass.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 32'd2_000_000_000: watchdog limit per pass, in clk cycles. Used only with the watchdog compiled in.
- `SUM_W`, default 40: width of the time accumulators. Must be ≥ 32 + 8.

Ports:
- `clk`  in  1  sole clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `cmd_start`  in  1  single-cycle request to begin a run.
- `cmd_mode`  in  2  bit0 = write pass, bit1 = read pass. 3 means write then read in each iteration.
- `cmd_iterations`  in  8  number of iterations.
- `start_write`  out  1  one-cycle pulse to the traffic generator.
- `start_read`  out  1  one-cycle pulse to the traffic generator.
- `write_busy`, `read_busy`  in  1  busy flags from the traffic generator.
- `write_time`, `read_time`  in  32  pass durations from the traffic generator.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle pulse when a run completes or aborts.
- `timeout_err`  out  1  sticky; cleared on the next accepted `cmd_start`.
- `iter_done`  out  8  iterations completed in the current run.
- `w_min`, `w_max`, `r_min`, `r_max`  out  32  statistics.
- `w_sum`, `r_sum`  out  SUM_W  accumulated times.
- `w_count`, `r_count`  out  8  passes captured.

## Operation
- States:
  - IDLE
  - W_START
  - W_WAIT
  - R_START
  - R_WAIT
  - NEXT
- IDLE:
  - `cmd_start` is accepted only when `write_busy` = 0 and `read_busy` = 0. Otherwise it is ignored, with no error and no `done`.
  - On acceptance: latch mode and iterations, clear all statistics and `iter_done`, and clear `timeout_err`.
  - If mode = 0 or iterations = 0: go to NEXT, which emits `done` with zero passes.
  - Otherwise go to W_START if mode[0] is set, else R_START.
- W_START: `start_write` = 1 for this cycle only, then go to W_WAIT.
- W_WAIT:
  - When `write_busy` = 0, capture `write_time`.
  - Then go to R_START if mode[1] is set, else NEXT.
- R_START / R_WAIT: identical to the write states, using the read signals.
- NEXT:
  - `iter_done` += 1, except on the zero-pass path.
  - If `iter_done` + 1 ≥ iterations, or on the zero-pass path: `done` = 1 and go to IDLE.
  - Otherwise go back to the first pass state.
- Capture of a time value t:
  - min ← min(min, t); max ← max(max, t).
  - sum ← sum + t, zero-extended to SUM_W. The sum never wraps at 255 × (2^32 − 1).
  - count += 1.
- Cleared values: min = 32'hFFFF_FFFF, max = 0, sum = 0, count = 0.
- Another `cmd_start` during a run is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `start_write`, `start_read`, `busy`, `done`, `timeout_err` = 0.
  - `iter_done` = 0.
  - Statistics are at their cleared values.
- `cmd_start` sampled at edge N → `busy` and the first start pulse are high in cycle N+1.
- The generator's busy flag includes its own start input combinationally. The WAIT state first samples busy in the cycle after the pulse, so it never sees a false idle.
- Capture happens on the first WAIT-state edge at which the busy flag is 0. The generator updates its time output on the edge busy drops, so the captured value is the fresh one.
- Pass-to-pass gap: 2 cycles (NEXT state plus the START cycle). For mode 3, write→read adds 1 cycle.
- Reset asserted mid-run: everything returns to reset values immediately. No `done` is emitted. The traffic generator is not stopped by this block.

## Configuration
- `PCIE_BW_SEQ_WATCHDOG_EN` defined:
  - A 32-bit counter is cleared on entry to each WAIT state and increments every cycle while waiting.
  - When it reaches `TIMEOUT_CYCLES`: set `timeout_err`, pulse `done`, go to IDLE, and leave statistics as they are.
- Not defined:
  - No counter is built; WAIT states wait indefinitely.
  - `timeout_err` is tied to 0.

## Structure
- Package `pcie_bw_pkg` holds:
  - the state enum;
  - the `MODE_WRITE` = 2'b01, `MODE_READ` = 2'b10 and `MODE_BOTH` = 2'b11 constants;
  - the `STAT_MIN_INIT` constant.
- Sub-module `bw_stat_accum` (params `SUM_W`):
  - inputs `clear`, `capture`, `t[31:0]`;
  - outputs min/max/sum/count;
  - instantiated twice, once for write and once for read.

## Test plan
- Mode 1, 3 iterations; stub generator holds busy 100 cycles and returns times 100, 120, 90 → exactly 3 `start_write` pulses and 0 `start_read` pulses; `w_min` = 90, `w_max` = 120, `w_sum` = 310, `w_count` = 3, one `done`.
- Mode 3, 2 iterations → pulse order W, R, W, R; each start occurs only after the previous busy falls; `iter_done` = 2 at `done`.
- Iterations = 0 → `done` in cycle N+2; no start pulses; statistics at cleared values (`w_min` = FFFF_FFFF).
- `cmd_start` while `read_busy` = 1 → ignored; a second `cmd_start` mid-run is also ignored with no state change.
- Watchdog (TIMEOUT_CYCLES = 1000, busy stuck high) → `timeout_err` = 1 and `done` at 1000 cycles after entering WAIT; the next `cmd_start` clears `timeout_err`.
- `resetn` dropped during W_WAIT → all outputs return to reset values asynchronously; no `done`; a run restarts cleanly after release.

Source files
------------

// File: rtl/pcie_bw_pkg.sv
// pcie_bw_pkg: shared types and constants for the PCIe bandwidth sequencer.
//   state_t        sequencer FSM state encoding
//   MODE_*         cmd_mode bit meanings
//   STAT_MIN_INIT  cleared value of the running minimum
package pcie_bw_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_W_START = 3'd1,
      ST_W_WAIT  = 3'd2,
      ST_R_START = 3'd3,
      ST_R_WAIT  = 3'd4,
      ST_NEXT    = 3'd5
   } state_t;

   localparam logic [1:0]  MODE_WRITE    = 2'b01;
   localparam logic [1:0]  MODE_READ     = 2'b10;
   localparam logic [1:0]  MODE_BOTH     = 2'b11;
   localparam logic [31:0] STAT_MIN_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/bw_stat_accum.sv
// bw_stat_accum: min/max/sum/count of captured pass durations.
// Ports:
//   clk, resetn            clock, async active-low reset
//   clear                  return all statistics to cleared values
//   capture, t[31:0]       fold one duration into the statistics
//   stat_min, stat_max     running extremes (min clears to all-ones)
//   stat_sum[SUM_W-1:0]    zero-extended accumulation of t
//   stat_count[7:0]        number of captures since clear
module bw_stat_accum
   import pcie_bw_pkg::*;
#(
   parameter int SUM_W = 40
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear,
   input  logic             capture,
   input  logic [31:0]      t,
   output logic [31:0]      stat_min,
   output logic [31:0]      stat_max,
   output logic [SUM_W-1:0] stat_sum,
   output logic [7:0]       stat_count
);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stat_min   <= STAT_MIN_INIT;
         stat_max   <= '0;
         stat_sum   <= '0;
         stat_count <= '0;
      end else if (clear) begin
         stat_min   <= STAT_MIN_INIT;
         stat_max   <= '0;
         stat_sum   <= '0;
         stat_count <= '0;
      end else if (capture) begin
         if (t < stat_min) stat_min <= t;
         if (t > stat_max) stat_max <= t;
         stat_sum   <= stat_sum + {{(SUM_W-32){1'b0}}, t};
         stat_count <= stat_count + 8'd1;
      end
   end

endmodule

// File: rtl/pcie_bw_sequencer.sv
// pcie_bw_sequencer: runs a programmed number of write / read / write-then-read
// passes on the downstream AXI4 PCIe traffic generator and keeps per-direction
// min/max/sum/count of the reported pass times.
// Optional feature: define PCIE_BW_SEQ_WATCHDOG_EN to build a per-pass
// watchdog (TIMEOUT_CYCLES) that aborts the run and sets timeout_err.
// Ports:
//   clk, resetn                           clock, async active-low reset
//   cmd_start, cmd_mode, cmd_iterations   run request
//   start_write, start_read               one-cycle pulses to the generator
//   write_busy, read_busy                 generator busy flags
//   write_time, read_time                 generator pass durations
//   busy, done, timeout_err, iter_done    run status
//   w_*/r_* min/max/sum/count             per-direction statistics
//
// state    | meaning
// IDLE     | waiting for an accepted cmd_start
// W_START  | start_write pulse is high
// W_WAIT   | waiting for write_busy to fall, then capture write_time
// R_START  | start_read pulse is high
// R_WAIT   | waiting for read_busy to fall, then capture read_time
// NEXT     | count the iteration, finish or loop to the first pass
module pcie_bw_sequencer
   import pcie_bw_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_000_000_000,
   parameter int          SUM_W          = 40
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cmd_start,
   input  logic [1:0]       cmd_mode,
   input  logic [7:0]       cmd_iterations,
   output logic             start_write,
   output logic             start_read,
   input  logic             write_busy,
   input  logic             read_busy,
   input  logic [31:0]      write_time,
   input  logic [31:0]      read_time,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [7:0]       iter_done,
   output logic [31:0]      w_min,
   output logic [31:0]      w_max,
   output logic [31:0]      r_min,
   output logic [31:0]      r_max,
   output logic [SUM_W-1:0] w_sum,
   output logic [SUM_W-1:0] r_sum,
   output logic [7:0]       w_count,
   output logic [7:0]       r_count
);

   state_t     r_state, w_state_nxt;
   logic [1:0] r_mode;
   logic [7:0] r_iters;
   logic [7:0] r_iter_done;
   logic       r_zero;
   logic       r_start_write, r_start_read, r_busy, r_done;

   logic w_accept, w_zero_req, w_last, w_wd_expire;
   logic w_start_write_nxt, w_start_read_nxt, w_busy_nxt, w_done_nxt;
   logic w_cap_w, w_cap_r;

   assign w_accept   = (r_state == ST_IDLE) && cmd_start && !write_busy && !read_busy;
   assign w_zero_req = ((cmd_mode & MODE_BOTH) == 2'b00) || (cmd_iterations == 8'd0);
   assign w_last     = r_zero || (({1'b0, r_iter_done} + 9'd1) >= {1'b0, r_iters});

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_zero_req)                        w_state_nxt = ST_NEXT;
               else if ((cmd_mode & MODE_WRITE) != 0) w_state_nxt = ST_W_START;
               else                                   w_state_nxt = ST_R_START;
            end
         end
         ST_W_START: w_state_nxt = ST_W_WAIT;
         ST_W_WAIT: begin
            if (!write_busy)
               w_state_nxt = ((r_mode & MODE_READ) != 0) ? ST_R_START : ST_NEXT;
            else if (w_wd_expire)
               w_state_nxt = ST_IDLE;
         end
         ST_R_START: w_state_nxt = ST_R_WAIT;
         ST_R_WAIT: begin
            if (!read_busy)       w_state_nxt = ST_NEXT;
            else if (w_wd_expire) w_state_nxt = ST_IDLE;
         end
         ST_NEXT: begin
            if (w_last)                          w_state_nxt = ST_IDLE;
            else if ((r_mode & MODE_WRITE) != 0) w_state_nxt = ST_W_START;
            else                                 w_state_nxt = ST_R_START;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so that the registered copies
   // line up with the state they describe.
   always_comb begin
      w_start_write_nxt = (w_state_nxt == ST_W_START);
      w_start_read_nxt  = (w_state_nxt == ST_R_START);
      w_busy_nxt        = (w_state_nxt != ST_IDLE);
      w_done_nxt        = ((r_state == ST_NEXT) && w_last) || w_wd_expire;
      w_cap_w           = (r_state == ST_W_WAIT) && !write_busy;
      w_cap_r           = (r_state == ST_R_WAIT) && !read_busy;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mode        <= 2'b00;
         r_iters       <= 8'd0;
         r_zero        <= 1'b0;
         r_iter_done   <= 8'd0;
         r_start_write <= 1'b0;
         r_start_read  <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_start_write <= w_start_write_nxt;
         r_start_read  <= w_start_read_nxt;
         r_busy        <= w_busy_nxt;
         r_done        <= w_done_nxt;
         if (w_accept) begin
            r_mode      <= cmd_mode;
            r_iters     <= cmd_iterations;
            r_zero      <= w_zero_req;
            r_iter_done <= 8'd0;
         end else if ((r_state == ST_NEXT) && !r_zero) begin
            r_iter_done <= r_iter_done + 8'd1;
         end
      end
   end

`ifdef PCIE_BW_SEQ_WATCHDOG_EN
   logic [31:0] r_wd_cnt;
   logic        r_timeout_err;
   logic        w_waiting;

   assign w_waiting   = ((r_state == ST_W_WAIT) && write_busy) ||
                        ((r_state == ST_R_WAIT) && read_busy);
   // Count reads 0 in the first WAIT cycle, so expiry lands TIMEOUT_CYCLES
   // edges after WAIT was entered.
   assign w_wd_expire = w_waiting && (r_wd_cnt == (TIMEOUT_CYCLES - 32'd1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wd_cnt      <= 32'd0;
         r_timeout_err <= 1'b0;
      end else begin
         if ((r_state == ST_W_START) || (r_state == ST_R_START)) r_wd_cnt <= 32'd0;
         else if (w_waiting)                                      r_wd_cnt <= r_wd_cnt + 32'd1;
         if (w_accept)         r_timeout_err <= 1'b0;
         else if (w_wd_expire) r_timeout_err <= 1'b1;
      end
   end

   assign timeout_err = r_timeout_err;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
   assign w_wd_expire      = 1'b0;
   assign timeout_err      = 1'b0;
`endif

   assign start_write = r_start_write;
   assign start_read  = r_start_read;
   assign busy        = r_busy;
   assign done        = r_done;
   assign iter_done   = r_iter_done;

   bw_stat_accum #(.SUM_W(SUM_W)) u_w_stat (
      .clk        (clk),
      .resetn     (resetn),
      .clear      (w_accept),
      .capture    (w_cap_w),
      .t          (write_time),
      .stat_min   (w_min),
      .stat_max   (w_max),
      .stat_sum   (w_sum),
      .stat_count (w_count)
   );

   bw_stat_accum #(.SUM_W(SUM_W)) u_r_stat (
      .clk        (clk),
      .resetn     (resetn),
      .clear      (w_accept),
      .capture    (w_cap_r),
      .t          (read_time),
      .stat_min   (r_min),
      .stat_max   (r_max),
      .stat_sum   (r_sum),
      .stat_count (r_count)
   );

endmodule

// File: tb/tb_pcie_bw_sequencer.sv
// tb_pcie_bw_sequencer: bench for pcie_bw_sequencer with a stub traffic
// generator; table-driven runs plus hand-written corner sequences.
module tb_pcie_bw_sequencer;

   localparam int SUM_W = 40;

   logic             clk = 1'b0;
   logic             resetn = 1'b0;
   logic             cmd_start = 1'b0;
   logic [1:0]       cmd_mode = 2'b00;
   logic [7:0]       cmd_iterations = 8'd0;
   logic             start_write, start_read;
   logic             write_busy, read_busy;
   logic [31:0]      write_time = 32'd0;
   logic [31:0]      read_time = 32'd0;
   logic             busy, done, timeout_err;
   logic [7:0]       iter_done;
   logic [31:0]      w_min, w_max, r_min, r_max;
   logic [SUM_W-1:0] w_sum, r_sum;
   logic [7:0]       w_count, r_count;

   always #5 clk = ~clk;

   pcie_bw_sequencer #(.TIMEOUT_CYCLES(32'd1000), .SUM_W(SUM_W)) dut (
      .clk(clk), .resetn(resetn), .cmd_start(cmd_start), .cmd_mode(cmd_mode),
      .cmd_iterations(cmd_iterations), .start_write(start_write), .start_read(start_read),
      .write_busy(write_busy), .read_busy(read_busy), .write_time(write_time),
      .read_time(read_time), .busy(busy), .done(done), .timeout_err(timeout_err),
      .iter_done(iter_done), .w_min(w_min), .w_max(w_max), .r_min(r_min), .r_max(r_max),
      .w_sum(w_sum), .r_sum(r_sum), .w_count(w_count), .r_count(r_count)
   );

   // ---------------- stub traffic generator ----------------
   logic        gw_act = 1'b0, gr_act = 1'b0, w_stuck = 1'b0, r_stuck = 1'b0;
   int          gw_cnt = 0, gr_cnt = 0, wi = 0, ri = 0, wi_base = 0, ri_base = 0, lat = 6;
   logic [31:0] w_tv[4];
   logic [31:0] r_tv[4];

   always @(posedge clk) begin
      if (start_write) begin
         gw_act <= 1'b1; gw_cnt <= lat;
      end else if (gw_act) begin
         if (gw_cnt <= 1) begin
            gw_act <= 1'b0; write_time <= w_tv[(wi - wi_base) & 3]; wi <= wi + 1;
         end else gw_cnt <= gw_cnt - 1;
      end
      if (start_read) begin
         gr_act <= 1'b1; gr_cnt <= lat;
      end else if (gr_act) begin
         if (gr_cnt <= 1) begin
            gr_act <= 1'b0; read_time <= r_tv[(ri - ri_base) & 3]; ri <= ri + 1;
         end else gr_cnt <= gr_cnt - 1;
      end
   end

   assign write_busy = start_write | gw_act | w_stuck;
   assign read_busy  = start_read  | gr_act | r_stuck;

   // ---------------- checking ----------------
   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   int       n_sw = 0, n_sr = 0, n_done = 0;
   bit       ord_q[$];   // 0 = write pulse, 1 = read pulse

   always @(posedge clk) begin
      #1;
      if (start_write || start_read) begin
         // a new pass may only start once the previous one has finished
         chk("start_after_busy_fall", {62'd0, gw_act, gr_act}, 64'd0);
         if (start_write) begin n_sw++; ord_q.push_back(1'b0); end
         if (start_read)  begin n_sr++; ord_q.push_back(1'b1); end
      end
      if (done) n_done++;
   end

   typedef struct {
      logic [1:0]  mode;
      logic [7:0]  iters;
      int          lat;
      bit          poke;
      logic [31:0] wt[4];
      logic [31:0] rt[4];
      logic [31:0] ew_min, ew_max, er_min, er_max;
      logic [63:0] ew_sum, er_sum;
      logic [7:0]  ew_cnt, er_cnt, e_iter;
      int          e_nsw, e_nsr;
   } vec_t;

   vec_t vecs[8];
   vec_t exp_q[$];

   function automatic vec_t mk(input logic [1:0] m, input logic [7:0] it, input int lt, input bit pk,
                               input logic [31:0] w0, w1, w2, r0, r1,
                               input logic [31:0] wmn, wmx, input logic [63:0] ws, input logic [7:0] wc,
                               input logic [31:0] rmn, rmx, input logic [63:0] rs, input logic [7:0] rc,
                               input logic [7:0] ei, input int nsw, input int nsr);
      vec_t v;
      v.mode = m; v.iters = it; v.lat = lt; v.poke = pk;
      v.wt[0] = w0; v.wt[1] = w1; v.wt[2] = w2; v.wt[3] = 32'd0;
      v.rt[0] = r0; v.rt[1] = r1; v.rt[2] = 32'd0; v.rt[3] = 32'd0;
      v.ew_min = wmn; v.ew_max = wmx; v.ew_sum = ws; v.ew_cnt = wc;
      v.er_min = rmn; v.er_max = rmx; v.er_sum = rs; v.er_cnt = rc;
      v.e_iter = ei; v.e_nsw = nsw; v.e_nsr = nsr;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      vec_t e;
      int   k, kd;
      bit   got, zero;
      logic [63:0] ord_exp, ord_act;
      zero = (v.mode == 2'b00) || (v.iters == 8'd0);
      wi_base = wi; ri_base = ri; w_tv = v.wt; r_tv = v.rt; lat = v.lat;
      n_sw = 0; n_sr = 0; n_done = 0; ord_q.delete();
      exp_q.push_back(v);
      @(negedge clk);
      cmd_mode = v.mode; cmd_iterations = v.iters; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0; cmd_mode = 2'b00; cmd_iterations = 8'd0;
      chk({tag, "_busy_n1"}, {63'd0, busy}, 64'd1);
      chk({tag, "_start_n1"}, {62'd0, start_write, start_read},
          zero ? 64'd0 : (v.mode[0] ? 64'd2 : 64'd1));
      got = 1'b0; kd = -1;
      for (k = 0; k < 6000; k++) begin
         cmd_start = (v.poke && k == 5);
         if (cmd_start) begin cmd_mode = 2'b10; cmd_iterations = 8'd9; end
         if (done) begin got = 1'b1; kd = k; break; end
         @(negedge clk);
      end
      cmd_start = 1'b0;
      chk({tag, "_done_seen"}, {63'd0, got}, 64'd1);
      if (zero) chk({tag, "_zero_done_cycle"}, kd, 64'd1);
      repeat (3) @(negedge clk);
      e = exp_q.pop_front();
      chk({tag, "_done_count"}, n_done, 64'd1);
      chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
      chk({tag, "_w_min"}, {32'd0, w_min}, {32'd0, e.ew_min});
      chk({tag, "_w_max"}, {32'd0, w_max}, {32'd0, e.ew_max});
      chk({tag, "_w_sum"}, {24'd0, w_sum}, e.ew_sum);
      chk({tag, "_w_count"}, {56'd0, w_count}, {56'd0, e.ew_cnt});
      chk({tag, "_r_min"}, {32'd0, r_min}, {32'd0, e.er_min});
      chk({tag, "_r_max"}, {32'd0, r_max}, {32'd0, e.er_max});
      chk({tag, "_r_sum"}, {24'd0, r_sum}, e.er_sum);
      chk({tag, "_r_count"}, {56'd0, r_count}, {56'd0, e.er_cnt});
      chk({tag, "_iter_done"}, {56'd0, iter_done}, {56'd0, e.e_iter});
      chk({tag, "_n_start_write"}, n_sw, e.e_nsw);
      chk({tag, "_n_start_read"}, n_sr, e.e_nsr);
      // pulse order model: per iteration W then R for the enabled directions
      ord_exp = 64'd1; ord_act = 64'd1;
      if (!zero)
         for (int i = 0; i < int'(e.iters); i++) begin
            if (e.mode[0]) ord_exp = {ord_exp[62:0], 1'b0};
            if (e.mode[1]) ord_exp = {ord_exp[62:0], 1'b1};
         end
      foreach (ord_q[i]) ord_act = {ord_act[62:0], ord_q[i]};
      chk({tag, "_pulse_order"}, ord_act, ord_exp);
   endtask

   int k;
   bit got;

   initial begin
      vecs[0] = mk(2'd1, 8'd3, 100, 1'b0, 32'd100, 32'd120, 32'd90, 32'd0, 32'd0,
                   32'd90, 32'd120, 64'd310, 8'd3, 32'hFFFF_FFFF, 32'd0, 64'd0, 8'd0, 8'd3, 3, 0);
      vecs[1] = mk(2'd3, 8'd2, 6, 1'b0, 32'd10, 32'd20, 32'd0, 32'd30, 32'd5,
                   32'd10, 32'd20, 64'd30, 8'd2, 32'd5, 32'd30, 64'd35, 8'd2, 8'd2, 2, 2);
      vecs[2] = mk(2'd2, 8'd1, 6, 1'b0, 32'd0, 32'd0, 32'd0, 32'd7, 32'd0,
                   32'hFFFF_FFFF, 32'd0, 64'd0, 8'd0, 32'd7, 32'd7, 64'd7, 8'd1, 8'd1, 0, 1);
      vecs[3] = mk(2'd0, 8'd5, 6, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                   32'hFFFF_FFFF, 32'd0, 64'd0, 8'd0, 32'hFFFF_FFFF, 32'd0, 64'd0, 8'd0, 8'd0, 0, 0);
      vecs[4] = mk(2'd1, 8'd0, 6, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                   32'hFFFF_FFFF, 32'd0, 64'd0, 8'd0, 32'hFFFF_FFFF, 32'd0, 64'd0, 8'd0, 8'd0, 0, 0);
      vecs[5] = mk(2'd3, 8'd1, 6, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF, 8'd1, 32'd0, 32'd0, 64'd0, 8'd1, 8'd1, 1, 1);
      vecs[6] = mk(2'd1, 8'd3, 6, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h2_FFFF_FFFD, 8'd3, 32'hFFFF_FFFF, 32'd0, 64'd0, 8'd0, 8'd3, 3, 0);
      vecs[7] = mk(2'd1, 8'd2, 20, 1'b1, 32'd50, 32'd40, 32'd0, 32'd0, 32'd0,
                   32'd40, 32'd50, 64'd90, 8'd2, 32'hFFFF_FFFF, 32'd0, 64'd0, 8'd0, 8'd2, 2, 0);

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_start_pulses", {62'd0, start_write, start_read}, 64'd0);
      chk("rst_busy_done_to", {61'd0, busy, done, timeout_err}, 64'd0);
      chk("rst_iter_done", {56'd0, iter_done}, 64'd0);
      chk("rst_w_min", {32'd0, w_min}, 64'hFFFF_FFFF);
      chk("rst_r_max", {32'd0, r_max}, 64'd0);
      chk("rst_w_sum", {24'd0, w_sum}, 64'd0);
      chk("rst_r_count", {56'd0, r_count}, 64'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // cmd_start while read_busy is high is ignored
      r_stuck = 1'b1; n_sw = 0; n_sr = 0; n_done = 0;
      @(negedge clk);
      cmd_mode = 2'd1; cmd_iterations = 8'd1; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      repeat (4) @(negedge clk);
      chk("ign_busy", {63'd0, busy}, 64'd0);
      chk("ign_pulses", n_sw + n_sr, 64'd0);
      chk("ign_done", n_done, 64'd0);
      chk("ign_keeps_stats", {56'd0, w_count}, 64'd2);
      r_stuck = 1'b0;
      @(negedge clk);

`ifdef PCIE_BW_SEQ_WATCHDOG_EN
      // watchdog: busy stuck high during a write pass
      w_stuck = 1'b1; n_done = 0;
      cmd_mode = 2'd1; cmd_iterations = 8'd2; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      got = 1'b0;
      for (k = 0; k < 1200; k++) begin
         @(posedge clk); #1;
         if (start_write) begin got = 1'b1; break; end
      end
      chk("wd_start_seen", {63'd0, got}, 64'd1);
      got = 1'b0;
      for (k = 1; k <= 1200; k++) begin
         @(posedge clk); #1;
         if (done) begin got = 1'b1; break; end
      end
      chk("wd_done_seen", {63'd0, got}, 64'd1);
      chk("wd_done_latency", k, 64'd1001);
      chk("wd_timeout_err", {63'd0, timeout_err}, 64'd1);
      chk("wd_no_capture", {56'd0, w_count}, 64'd0);
      w_stuck = 1'b0;
      repeat (150) @(negedge clk);
      chk("wd_sticky", {63'd0, timeout_err}, 64'd1);
      cmd_mode = 2'd0; cmd_iterations = 8'd1; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("wd_cleared_on_start", {63'd0, timeout_err}, 64'd0);
      repeat (4) @(negedge clk);
`endif

      // reset asserted while waiting on the second write pass
      wi_base = wi; w_tv = vecs[1].wt; lat = 6; n_done = 0;
      cmd_mode = 2'd1; cmd_iterations = 8'd3; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      got = 1'b0;
      for (k = 0; k < 200; k++) begin
         if (w_count == 8'd1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      w_stuck = 1'b1;
      chk("rr_first_capture", {63'd0, got}, 64'd1);
      repeat (20) @(negedge clk);
      chk("rr_busy_mid", {63'd0, busy}, 64'd1);
      chk("rr_iter_mid", {56'd0, iter_done}, 64'd1);
      chk("rr_no_timeout", {63'd0, timeout_err}, 64'd0);
      #2 resetn = 1'b0;
      #1;
      chk("rr_busy", {63'd0, busy}, 64'd0);
      chk("rr_iter_done", {56'd0, iter_done}, 64'd0);
      chk("rr_w_stats", {w_min, 8'd0, w_count, 16'd0}, {32'hFFFF_FFFF, 32'd0});
      chk("rr_w_sum_max", {24'd0, w_sum} | {32'd0, w_max}, 64'd0);
      w_stuck = 1'b0;
      repeat (5) @(negedge clk);
      chk("rr_no_done", n_done, 64'd0);
      resetn = 1'b1;
      repeat (12) @(negedge clk);
      run_vec(vecs[1], "restart");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

endmodule
